edge_event_scheduler: RTL and testbench

- Collects rising/falling edge pulses from N_CH `edge_detector_rnm` instances, each sampling one wreal channel.
- Timestamps each event, arbitrates round-robin, and queues events into a small FIFO drained over a valid/ready interface.
- Sits between the analog-front-end edge detectors and the digital event consumer.

---
 rtl/edge_event_scheduler.sv | 147 ++++++++++++++
 tb/tb_edge_event_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_event_scheduler.sv
// Edge event scheduler: captures masked rise/fall pulses from N_CH detectors, stamps them,
// arbitrates round-robin over 2*N_CH requesters and queues {chan, rise, stamp} into a FIFO.
module edge_event_scheduler #(
   parameter int N_CH       = 4,
   parameter int TS_W       = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          enable_i,
   input  logic [N_CH-1:0]               rising_edge_i,
   input  logic [N_CH-1:0]               falling_edge_i,
   input  logic [N_CH-1:0]               rise_mask_i,
   input  logic [N_CH-1:0]               fall_mask_i,
   input  logic                          clear_ovf_i,
   output logic                          event_valid_o,
   input  logic                          event_ready_i,
   output logic [$clog2(N_CH)-1:0]       event_chan_o,
   output logic                          event_rise_o,
   output logic [TS_W-1:0]               event_time_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
   output logic                          overflow_o
);
   // Handshake: a head event transfers on any cycle where event_valid_o and event_ready_i are both 1.
   localparam int NREQ = 2 * N_CH;
   localparam int CW   = $clog2(N_CH);
   localparam int PW   = $clog2(NREQ);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int EW   = CW + 1 + TS_W;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);
   localparam logic [PW:0] NREQ_W   = (PW+1)'(NREQ);

   logic [TS_W-1:0] ts_q, ts_d;
   logic [NREQ-1:0] pend_q, pend_d;
   logic [TS_W-1:0] stamp_q [NREQ];
   logic [TS_W-1:0] stamp_d [NREQ];
   logic [PW-1:0]   rr_q, rr_d;
   logic            ovf_q, ovf_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     count_q, count_d;
   logic [EW-1:0]   mem_q [FIFO_DEPTH];

   logic [NREQ-1:0] req;
   logic            gnt_found, gnt_valid, push, pop, coll;
   logic [PW-1:0]   gnt_idx;
   logic [PW:0]     arb_sum;
   logic [EW-1:0]   entry, head;

   always_comb begin
      req = '0;
      for (int c = 0; c < N_CH; c++) begin
         req[2*c]   = enable_i & rising_edge_i[c]  & rise_mask_i[c];
         req[2*c+1] = enable_i & falling_edge_i[c] & fall_mask_i[c];
      end
   end

   // Scan offsets downward so the nearest pending index at or after rr_q wins last.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      arb_sum   = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         arb_sum = {1'b0, rr_q} + (PW+1)'(k);
         if (arb_sum >= NREQ_W) arb_sum = arb_sum - NREQ_W;
         if (pend_q[arb_sum[PW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = arb_sum[PW-1:0];
         end
      end
      gnt_valid = gnt_found && (count_q != FULL_CNT);
   end

   always_comb begin
      pend_d  = pend_q;
      stamp_d = stamp_q;
      coll    = 1'b0;
      rr_d    = rr_q;
      if (gnt_valid) rr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_valid && gnt_idx == PW'(i)) begin
            pend_d[i] = req[i];
            if (req[i]) stamp_d[i] = ts_q;
         end else if (req[i]) begin
            if (pend_q[i]) coll = 1'b1;
            else begin
               pend_d[i]  = 1'b1;
               stamp_d[i] = ts_q;
            end
         end
      end
      ovf_d = ovf_q;
      if (clear_ovf_i) ovf_d = 1'b0;
      if (coll) ovf_d = 1'b1;
      ts_d = enable_i ? ts_q + TS_W'(1) : ts_q;
   end

   always_comb begin
      push     = gnt_valid;
      pop      = (count_q != '0) && event_ready_i;
      entry    = {gnt_idx[PW-1:1], ~gnt_idx[0], stamp_q[gnt_idx]};
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + ONE_CNT;
         2'b01:   count_d = count_q - ONE_CNT;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ts_q     <= '0;
         pend_q   <= '0;
         rr_q     <= '0;
         ovf_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < NREQ; i++) stamp_q[i] <= '0;
      end else begin
         ts_q     <= ts_d;
         pend_q   <= pend_d;
         rr_q     <= rr_d;
         ovf_q    <= ovf_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < NREQ; i++) stamp_q[i] <= stamp_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= entry;
   end

   // Head fields read as zero whenever the queue is empty, including during reset.
   always_comb begin
      head          = mem_q[rd_ptr_q];
      event_valid_o = (count_q != '0);
      event_chan_o  = event_valid_o ? head[EW-1 -: CW] : '0;
      event_rise_o  = event_valid_o ? head[TS_W] : 1'b0;
      event_time_o  = event_valid_o ? head[TS_W-1:0] : '0;
      fifo_count_o  = count_q;
      overflow_o    = ovf_q;
   end
endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_edge_event_scheduler;
   localparam int N_CH = 4;
   localparam int TS_W = 4;
   localparam int DEPTH = 4;

   logic       clk, reset, enable_i, clear_ovf_i, event_ready_i;
   logic [3:0] rising_edge_i, falling_edge_i, rise_mask_i, fall_mask_i;
   logic       event_valid_o, event_rise_o, overflow_o;
   logic [1:0] event_chan_o;
   logic [3:0] event_time_o;
   logic [2:0] fifo_count_o;

   int cmp_cnt = 0;
   int err_cnt = 0;
   bit check_en = 0;

   edge_event_scheduler #(.N_CH(N_CH), .TS_W(TS_W), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .enable_i(enable_i),
      .rising_edge_i(rising_edge_i), .falling_edge_i(falling_edge_i),
      .rise_mask_i(rise_mask_i), .fall_mask_i(fall_mask_i),
      .clear_ovf_i(clear_ovf_i), .event_valid_o(event_valid_o),
      .event_ready_i(event_ready_i), .event_chan_o(event_chan_o),
      .event_rise_o(event_rise_o), .event_time_o(event_time_o),
      .fifo_count_o(fifo_count_o), .overflow_o(overflow_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: {chan, rise, time} queue of events the consumer must see
   logic [6:0] exp_q[$];
   bit m_pend [8];
   int m_stamp [8];
   int m_rr, m_ts, m_g;
   bit m_ovf, m_coll, m_req;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         for (int i = 0; i < 8; i++) begin
            m_pend[i] = 0;
            m_stamp[i] = 0;
         end
         m_rr = 0; m_ts = 0; m_ovf = 0;
      end else begin
         m_g = -1;
         if (exp_q.size() < DEPTH)
            for (int k = 0; k < 8; k++)
               if (m_g < 0 && m_pend[(m_rr + k) % 8]) m_g = (m_rr + k) % 8;
         if (exp_q.size() != 0 && event_ready_i) void'(exp_q.pop_front());
         if (m_g >= 0) begin
            exp_q.push_back({2'(m_g / 2), (m_g % 2 == 0) ? 1'b1 : 1'b0, 4'(m_stamp[m_g])});
            m_rr = (m_g + 1) % 8;
         end
         m_coll = 0;
         for (int i = 0; i < 8; i++) begin
            m_req = enable_i && ((i % 2 == 0) ? (rising_edge_i[i/2] && rise_mask_i[i/2])
                                              : (falling_edge_i[i/2] && fall_mask_i[i/2]));
            if (i == m_g) begin
               m_pend[i] = m_req;
               if (m_req) m_stamp[i] = m_ts;
            end else if (m_req) begin
               if (m_pend[i]) m_coll = 1;
               else begin
                  m_pend[i] = 1;
                  m_stamp[i] = m_ts;
               end
            end
         end
         if (clear_ovf_i) m_ovf = 0;
         if (m_coll) m_ovf = 1;
         if (enable_i) m_ts = (m_ts + 1) % 16;
      end
   end

   // scoreboard compare, once per cycle on the falling edge
   always @(negedge clk) begin
      if (check_en && !reset) begin
         chk("valid", event_valid_o, exp_q.size() != 0);
         chk("count", fifo_count_o, exp_q.size());
         chk("overflow", overflow_o, m_ovf);
         if (exp_q.size() != 0) begin
            chk("chan", event_chan_o, exp_q[0][6:5]);
            chk("rise", event_rise_o, exp_q[0][4]);
            chk("time", event_time_o, exp_q[0][3:0]);
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_ts(input int v);
      int n;
      n = 0;
      while (m_ts != v && n < 64) begin
         tick();
         n++;
      end
      if (n >= 64) chk("wait_ts_timeout", m_ts, v);
   endtask

   task automatic fire(input logic [3:0] r, input logic [3:0] f);
      rising_edge_i = r;
      falling_edge_i = f;
      tick();
      rising_edge_i = '0;
      falling_edge_i = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      err_cnt++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $fatal(1, "watchdog");
   end

   int n_ev, s0;
   int times [2];

   initial begin
      reset = 1; enable_i = 0; clear_ovf_i = 0; event_ready_i = 0;
      rising_edge_i = '0; falling_edge_i = '0; rise_mask_i = 4'hF; fall_mask_i = 4'hF;
      repeat (3) tick();
      chk("rst_valid", event_valid_o, 0);
      chk("rst_count", fifo_count_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_chan", event_chan_o, 0);
      chk("rst_time", event_time_o, 0);
      reset = 0; check_en = 1; enable_i = 1; event_ready_i = 1;

      // single event at counter 5
      wait_ts(5);
      fire(4'b0010, 4'b0000);
      chk("single_early_valid", event_valid_o, 0);
      tick();
      chk("single_valid", event_valid_o, 1);
      chk("single_chan", event_chan_o, 1);
      chk("single_rise", event_rise_o, 1);
      chk("single_time", event_time_o, 5);
      tick();
      chk("single_popped_valid", event_valid_o, 0);
      chk("single_popped_count", fifo_count_o, 0);

      // contention: all four rising edges at counter 10 with the pointer at 0
      reset = 1; tick(); reset = 0;
      wait_ts(10);
      fire(4'b1111, 4'b0000);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("cont_valid", event_valid_o, 1);
         chk("cont_chan", event_chan_o, k);
         chk("cont_time", event_time_o, 10);
         chk("cont_ovf", overflow_o, 0);
         tick();
      end

      // backpressure: five requesters, FIFO holds four, repeat hit on the waiting one
      event_ready_i = 0;
      s0 = m_ts;
      fire(4'b1111, 4'b0001);
      repeat (6) tick();
      chk("bp_full_count", fifo_count_o, 4);
      chk("bp_no_ovf", overflow_o, 0);
      fire(4'b1000, 4'b0000);
      chk("bp_ovf", overflow_o, 1);
      chk("bp_still_full", fifo_count_o, 4);
      event_ready_i = 1;
      n_ev = 0;
      for (int k = 0; k < 12; k++) begin
         if (event_valid_o) begin
            n_ev++;
            chk("bp_stamp", event_time_o, 4'(s0));
         end
         tick();
      end
      chk("bp_drained", n_ev, 5);
      clear_ovf_i = 1; tick(); clear_ovf_i = 0;
      chk("bp_ovf_cleared", overflow_o, 0);

      // wrap: edge at counter 15, same requester again at counter 0 while being granted
      wait_ts(15);
      rising_edge_i = 4'b0001;
      tick();
      rising_edge_i = 4'b0001;
      tick();
      rising_edge_i = '0;
      n_ev = 0;
      for (int k = 0; k < 8; k++) begin
         if (event_valid_o && n_ev < 2) begin
            times[n_ev] = int'(event_time_o);
            n_ev++;
         end
         tick();
      end
      chk("wrap_count", n_ev, 2);
      chk("wrap_t0", times[0], 15);
      chk("wrap_t1", times[1], 0);
      chk("wrap_ovf", overflow_o, 0);

      // mask and enable gating
      fall_mask_i = 4'b1011;
      fire(4'b0000, 4'b0100);
      fall_mask_i = 4'hF;
      repeat (3) begin
         chk("mask_no_event", event_valid_o, 0);
         tick();
      end
      wait_ts(3);
      enable_i = 0;
      fire(4'b0001, 4'b0000);
      repeat (3) begin
         chk("dis_no_event", event_valid_o, 0);
         tick();
      end
      enable_i = 1;
      fire(4'b0100, 4'b0000);
      tick();
      chk("frozen_valid", event_valid_o, 1);
      chk("frozen_chan", event_chan_o, 2);
      chk("frozen_time", event_time_o, 3);
      tick();

      // reset mid-operation: three queued, two pending
      event_ready_i = 0;
      fire(4'b1111, 4'b0001);
      repeat (3) tick();
      chk("mid_count", fifo_count_o, 3);
      @(posedge clk);
      #2 reset = 1;
      #1;
      chk("mid_rst_valid", event_valid_o, 0);
      chk("mid_rst_count", fifo_count_o, 0);
      chk("mid_rst_ovf", overflow_o, 0);
      chk("mid_rst_chan", event_chan_o, 0);
      chk("mid_rst_time", event_time_o, 0);
      tick();
      reset = 0; event_ready_i = 1;
      repeat (10) begin
         chk("mid_no_stale", event_valid_o, 0);
         tick();
      end

      check_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
